// File: rtl/peripheral_dbg_pu_riscv_biu_arbiter.sv
// -----------------------------------------------------------------------------
// peripheral_dbg_pu_riscv_biu_arbiter
//
// Shares one debug Bus Interface Unit among NUM_REQ debug bus-module cores
// (typically one per hart). Requests are granted round-robin, one access is
// in flight at a time, and the owner's rw/addr/data/size are latched at grant
// so the BIU sees stable fields for the whole access. A watchdog aborts an
// access the BIU never acknowledges (TIMEOUT = 0 disables it).
//
// Ports
//   biu_clk, biu_rst      clock, synchronous active-high reset
//   req_strb_i[k]         requester k strobe, level, held until its req_rdy_o
//   req_rw_i[k]           1 = write, 0 = read
//   req_addr_i            packed addresses, requester k at [k*AW +: AW]
//   req_di_i              packed write data, requester k at [k*DW +: DW]
//   req_word_size_i       packed byte counts, requester k at [k*4 +: 4]
//   req_do_o              read data of the last completed read
//   req_rdy_o[k]          one-cycle completion pulse to requester k
//   req_err_o[k]          error flag, valid with req_rdy_o[k]
//   grant_o               one-hot current owner, zero when no access is active
//   timeout_o             one-cycle pulse when the watchdog aborts an access
//   biu_strb_o            strobe to BIU, held until biu_rdy_i (or abort)
//   biu_rw_o, biu_addr_o, biu_di_o, biu_word_size_o   latched access fields
//   biu_do_i, biu_rdy_i, biu_err_i                     BIU response
// -----------------------------------------------------------------------------
module peripheral_dbg_pu_riscv_biu_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          biu_clk,
  input  logic                          biu_rst,

  input  logic [NUM_REQ-1:0]            req_strb_i,
  input  logic [NUM_REQ-1:0]            req_rw_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_di_i,
  input  logic [NUM_REQ*4-1:0]          req_word_size_i,
  output logic [DATA_WIDTH-1:0]         req_do_o,
  output logic [NUM_REQ-1:0]            req_rdy_o,
  output logic [NUM_REQ-1:0]            req_err_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          timeout_o,

  output logic                          biu_strb_o,
  output logic                          biu_rw_o,
  output logic [ADDR_WIDTH-1:0]         biu_addr_o,
  output logic [DATA_WIDTH-1:0]         biu_di_o,
  output logic [3:0]                    biu_word_size_o,
  input  logic [DATA_WIDTH-1:0]         biu_do_i,
  input  logic                          biu_rdy_i,
  input  logic                          biu_err_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  // After reset the search starts just past the last requester, so req 0 wins first.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       last_grant_reg, last_grant_next;

  logic [NUM_REQ-1:0]     grant_next, rdy_next, err_next;
  logic [DATA_WIDTH-1:0]  do_next, di_next;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [3:0]             ws_next;
  logic                   strb_next, rw_next, timeout_next;

  // Unpacked views of the packed requester buses.
  logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  di_arr   [NUM_REQ];
  logic [3:0]             ws_arr   [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign di_arr[gi]   = req_di_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign ws_arr[gi]   = req_word_size_i[gi*4 +: 4];
    end
  endgenerate

  // Round-robin pick: first asserted strobe searching upward from last_grant+1.
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(last_grant_reg) + 1 + i) % NUM_REQ);
      if (!pick_valid && req_strb_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_o;
    strb_next       = biu_strb_o;
    rw_next         = biu_rw_o;
    addr_next       = biu_addr_o;
    di_next         = biu_di_o;
    ws_next         = biu_word_size_o;
    do_next         = req_do_o;
    rdy_next        = '0;
    err_next        = '0;
    timeout_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next      = ST_BUSY;
          cnt_next        = '0;
          last_grant_next = pick_idx;
          grant_next      = NUM_REQ'(1) << pick_idx;
          strb_next       = 1'b1;
          rw_next         = req_rw_i[pick_idx];
          addr_next       = addr_arr[pick_idx];
          di_next         = di_arr[pick_idx];
          ws_next         = ws_arr[pick_idx];
        end
      end

      ST_BUSY: begin
        // A BIU ack on the expiry cycle still counts as a normal completion.
        if (biu_rdy_i) begin
          state_next = ST_RELEASE;
          strb_next  = 1'b0;
          grant_next = '0;
          rdy_next   = grant_o;
          err_next   = biu_err_i ? grant_o : '0;
          if (!biu_rw_o) begin
            do_next = biu_do_i;
          end
        end else if (TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
          state_next   = ST_RELEASE;
          strb_next    = 1'b0;
          grant_next   = '0;
          rdy_next     = grant_o;
          err_next     = grant_o;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // One dead cycle so the owner can drop its strobe before re-arbitration.
      ST_RELEASE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge biu_clk) begin
    if (biu_rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      last_grant_reg  <= LAST_RST;
      grant_o         <= '0;
      biu_strb_o      <= 1'b0;
      biu_rw_o        <= 1'b0;
      biu_addr_o      <= '0;
      biu_di_o        <= '0;
      biu_word_size_o <= '0;
      req_do_o        <= '0;
      req_rdy_o       <= '0;
      req_err_o       <= '0;
      timeout_o       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      last_grant_reg  <= last_grant_next;
      grant_o         <= grant_next;
      biu_strb_o      <= strb_next;
      biu_rw_o        <= rw_next;
      biu_addr_o      <= addr_next;
      biu_di_o        <= di_next;
      biu_word_size_o <= ws_next;
      req_do_o        <= do_next;
      req_rdy_o       <= rdy_next;
      req_err_o       <= err_next;
      timeout_o       <= timeout_next;
    end
  end

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_biu_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for peripheral_dbg_pu_riscv_biu_arbiter (NUM_REQ=4, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_peripheral_dbg_pu_riscv_biu_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_strb, req_rw;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_di;
  logic [N*4-1:0]  req_ws;
  logic [DW-1:0]   req_do;
  logic [N-1:0]    req_rdy, req_err, grant;
  logic            timeout;
  logic            biu_strb, biu_rw;
  logic [AW-1:0]   biu_addr;
  logic [DW-1:0]   biu_di;
  logic [3:0]      biu_ws;
  logic [DW-1:0]   biu_do;
  logic            biu_rdy, biu_err;

  always #5 clk = ~clk;

  peripheral_dbg_pu_riscv_biu_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .biu_clk(clk), .biu_rst(rst),
    .req_strb_i(req_strb), .req_rw_i(req_rw), .req_addr_i(req_addr),
    .req_di_i(req_di), .req_word_size_i(req_ws),
    .req_do_o(req_do), .req_rdy_o(req_rdy), .req_err_o(req_err),
    .grant_o(grant), .timeout_o(timeout),
    .biu_strb_o(biu_strb), .biu_rw_o(biu_rw), .biu_addr_o(biu_addr),
    .biu_di_o(biu_di), .biu_word_size_o(biu_ws),
    .biu_do_i(biu_do), .biu_rdy_i(biu_rdy), .biu_err_i(biu_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Bench-side record of what each requester is currently presenting.
  logic          rq_rw   [N];
  logic [31:0]   rq_addr [N];
  logic [31:0]   rq_di   [N];
  logic [3:0]    rq_ws   [N];
  logic [31:0]   model_do;

  typedef struct {
    logic [3:0]  grant;
    logic        strb;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] di;
    logic [3:0]  ws;
    logic        stable;
    int          cyc;
    logic [3:0]  rdy;
    logic [3:0]  err;
    logic [31:0] dout;
    logic        tmo;
    logic [3:0]  grant_after;
    logic        strb_after;
    logic [3:0]  rdy_after;
    logic        tmo_after;
  } obs_t;

  typedef struct {
    int          k;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] di;
    logic [3:0]  ws;
    int          d;
    logic [31:0] bdo;
    logic        berr;
    logic [31:0] exp_do;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req_strb = '0;
    biu_rdy  = 1'b0;
    biu_err  = 1'b0;
    biu_do   = '0;
    model_do = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic raise(input int k, input logic rw, input logic [31:0] addr,
                       input logic [31:0] di, input logic [3:0] ws);
    rq_rw[k] = rw; rq_addr[k] = addr; rq_di[k] = di; rq_ws[k] = ws;
    req_rw[k]             = rw;
    req_addr[k*AW +: AW]  = addr;
    req_di[k*DW +: DW]    = di;
    req_ws[k*4 +: 4]      = ws;
    req_strb[k]           = 1'b1;
  endtask

  // Plays the BIU for one access: acks d cycles after the strobe is seen
  // (d = 0: never acks), then clears the strobes in drop while in RELEASE.
  task automatic serve(input int d, input logic [31:0] bdo, input logic berr,
                       input logic [3:0] drop, output obs_t o);
    int cyc;
    bit done;
    @(negedge clk);
    o.grant = grant; o.strb = biu_strb; o.rw = biu_rw;
    o.addr = biu_addr; o.di = biu_di; o.ws = biu_ws;
    o.stable = 1'b1;
    o.rdy = '0; o.err = '0; o.dout = req_do; o.tmo = 1'b0;
    o.grant_after = grant; o.strb_after = biu_strb;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      if (d > 0 && cyc == d - 1) begin
        biu_rdy = 1'b1; biu_do = bdo; biu_err = berr;
      end else begin
        biu_rdy = 1'b0; biu_err = 1'b0; biu_do = $urandom;
      end
      @(negedge clk);
      cyc++;
      if (req_rdy != '0) begin
        done = 1'b1;
        o.rdy = req_rdy; o.err = req_err; o.dout = req_do; o.tmo = timeout;
        o.grant_after = grant; o.strb_after = biu_strb;
      end else if (!biu_strb || biu_addr != o.addr || biu_rw != o.rw ||
                   biu_di != o.di || biu_ws != o.ws || grant != o.grant) begin
        o.stable = 1'b0;
      end
    end
    biu_rdy = 1'b0;
    biu_err = 1'b0;
    o.cyc = done ? cyc : -1;
    req_strb = req_strb & ~drop;
    @(negedge clk);
    o.rdy_after = req_rdy;
    o.tmo_after = timeout;
  endtask

  // Expected outcome straight from the access rules.
  task automatic predict(input int k, input int d, input logic [31:0] bdo, input logic berr,
                         output int cyc, output logic err, output logic [31:0] dout,
                         output logic tmo);
    if (d == 0 || d > TMO) begin
      cyc = TMO; err = 1'b1; tmo = 1'b1;
    end else begin
      cyc = d; err = berr; tmo = 1'b0;
      if (!rq_rw[k]) model_do = bdo;
    end
    dout = model_do;
  endtask

  task automatic check_obs(input string tag, input obs_t o, input int k, input int exp_cyc,
                           input logic exp_err, input logic [31:0] exp_do, input logic exp_tmo);
    logic [3:0] oh;
    oh = 4'(1) << k;
    $display("txn %s: req%0d rw=%0d addr=%08h cyc=%0d rdy=%b err=%b tmo=%0d do=%08h",
             tag, k, o.rw, o.addr, o.cyc, o.rdy, o.err, o.tmo, o.dout);
    check({tag, ".grant"},       64'(o.grant), 64'(oh));
    check({tag, ".biu_strb"},    64'(o.strb), 64'd1);
    check({tag, ".biu_rw"},      64'(o.rw), 64'(rq_rw[k]));
    check({tag, ".biu_addr"},    64'(o.addr), 64'(rq_addr[k]));
    check({tag, ".biu_di"},      64'(o.di), 64'(rq_di[k]));
    check({tag, ".biu_ws"},      64'(o.ws), 64'(rq_ws[k]));
    check({tag, ".stable"},      64'(o.stable), 64'd1);
    check({tag, ".cycles"},      64'(o.cyc), 64'(exp_cyc));
    check({tag, ".rdy"},         64'(o.rdy), 64'(oh));
    check({tag, ".err"},         64'(o.err), exp_err ? 64'(oh) : 64'd0);
    check({tag, ".do"},          64'(o.dout), 64'(exp_do));
    check({tag, ".timeout"},     64'(o.tmo), 64'(exp_tmo));
    check({tag, ".grant_rel"},   64'(o.grant_after), 64'd0);
    check({tag, ".strb_rel"},    64'(o.strb_after), 64'd0);
    check({tag, ".rdy_pulse"},   64'(o.rdy_after), 64'd0);
    check({tag, ".tmo_pulse"},   64'(o.tmo_after), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    obs_t        o;
    int          ecyc, last_m, w, d;
    logic        eerr, etmo, berr;
    logic [31:0] edo, bdo;
    logic [3:0]  ws;

    req_strb = '0; req_rw = '0; req_addr = '0; req_di = '0; req_ws = '0;
    for (int k = 0; k < N; k++) begin
      rq_rw[k] = 1'b0; rq_addr[k] = '0; rq_di[k] = '0; rq_ws[k] = '0;
    end

    //            k rw    addr          di            ws    d   bdo           berr  exp_do        err   tmo   cyc
    vecs[0] = '{0, 1'b0, 32'h0000_1000, 32'h0,        4'd4, 5,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 5};
    vecs[1] = '{1, 1'b1, 32'h0000_2004, 32'h12345678, 4'd4, 2,  32'hAAAA5555, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 2};
    vecs[2] = '{2, 1'b0, 32'h0000_3000, 32'h0,        4'd2, 1,  32'h0000BEEF, 1'b0, 32'h0000BEEF, 1'b0, 1'b0, 1};
    vecs[3] = '{3, 1'b0, 32'h0000_4000, 32'h0,        4'd1, 16, 32'h00000011, 1'b1, 32'h00000011, 1'b1, 1'b0, 16};
    vecs[4] = '{0, 1'b1, 32'h0000_5000, 32'hCAFEF00D, 4'd4, 0,  32'h0,        1'b0, 32'h00000011, 1'b1, 1'b1, 16};
    vecs[5] = '{1, 1'b0, 32'h0000_6000, 32'h0,        4'd4, 3,  32'h87654321, 1'b0, 32'h87654321, 1'b0, 1'b0, 3};

    // Reset state
    rst = 1'b1; biu_rdy = 1'b0; biu_err = 1'b0; biu_do = '0;
    repeat (3) @(negedge clk);
    check("reset.grant",    64'(grant), 64'd0);
    check("reset.biu_strb", 64'(biu_strb), 64'd0);
    check("reset.rdy",      64'(req_rdy), 64'd0);
    check("reset.err",      64'(req_err), 64'd0);
    check("reset.do",       64'(req_do), 64'd0);
    check("reset.timeout",  64'(timeout), 64'd0);
    check("reset.biu_addr", 64'(biu_addr), 64'd0);
    rst = 1'b0;

    // Table of single accesses
    for (int i = 0; i < 6; i++) begin
      raise(vecs[i].k, vecs[i].rw, vecs[i].addr, vecs[i].di, vecs[i].ws);
      serve(vecs[i].d, vecs[i].bdo, vecs[i].berr, 4'(1) << vecs[i].k, o);
      check_obs($sformatf("vec%0d", i), o, vecs[i].k, vecs[i].exp_cyc,
                vecs[i].exp_err, vecs[i].exp_do, vecs[i].exp_tmo);
    end

    // Contention: req0 and req1 both held -> 0,1,0,1
    do_reset();
    raise(0, 1'b0, 32'h0000_A000, 32'h0,        4'd4);
    raise(1, 1'b1, 32'h0000_B000, 32'h0BADC0DE, 4'd4);
    for (int i = 0; i < 4; i++) begin
      bdo = 32'h1000_0000 + 32'(i);
      serve(i + 1, bdo, 1'b0, (i == 3) ? 4'b0011 : 4'b0000, o);
      w = i % 2;
      predict(w, i + 1, bdo, 1'b0, ecyc, eerr, edo, etmo);
      check_obs($sformatf("contend%0d", i), o, w, ecyc, eerr, edo, etmo);
    end

    // Watchdog abort, then a late BIU ack that must be ignored
    do_reset();
    raise(2, 1'b0, 32'h0000_C000, 32'h0, 4'd4);
    serve(0, 32'h0, 1'b0, 4'b0100, o);
    predict(2, 0, 32'h0, 1'b0, ecyc, eerr, edo, etmo);
    check_obs("timeout", o, 2, ecyc, eerr, edo, etmo);
    @(negedge clk);
    biu_rdy = 1'b1; biu_err = 1'b1; biu_do = 32'h5555_AAAA;
    @(negedge clk);
    biu_rdy = 1'b0; biu_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("late_ack.rdy",   64'(req_rdy), 64'd0);
      check("late_ack.err",   64'(req_err), 64'd0);
      check("late_ack.do",    64'(req_do), 64'(model_do));
      check("late_ack.strb",  64'(biu_strb), 64'd0);
      @(negedge clk);
    end

    // Reset during BUSY drops the access; pending req1 goes first afterwards
    do_reset();
    raise(0, 1'b0, 32'h0000_7000, 32'h0, 4'd4);
    @(negedge clk);
    check("rstbusy.grant0", 64'(grant), 64'b0001);
    check("rstbusy.strb0",  64'(biu_strb), 64'd1);
    raise(1, 1'b1, 32'h0000_7100, 32'h11112222, 4'd4);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req_strb[0] = 1'b0;
    @(negedge clk);
    check("rstbusy.grant",  64'(grant), 64'd0);
    check("rstbusy.strb",   64'(biu_strb), 64'd0);
    check("rstbusy.rdy",    64'(req_rdy), 64'd0);
    check("rstbusy.err",    64'(req_err), 64'd0);
    check("rstbusy.addr",   64'(biu_addr), 64'd0);
    rst = 1'b0;
    model_do = '0;
    serve(2, 32'h33, 1'b0, 4'b0010, o);
    predict(1, 2, 32'h33, 1'b0, ecyc, eerr, edo, etmo);
    check_obs("rstbusy.req1", o, 1, ecyc, eerr, edo, etmo);
    raise(0, 1'b0, 32'h0000_7000, 32'h0, 4'd4);
    serve(1, 32'h44, 1'b0, 4'b0001, o);
    predict(0, 1, 32'h44, 1'b0, ecyc, eerr, edo, etmo);
    check_obs("rstbusy.req0", o, 0, ecyc, eerr, edo, etmo);

    // Wrap: last owner 3, strobes on 1 and 2 -> 1 then 2
    do_reset();
    raise(3, 1'b1, 32'h0000_D000, 32'h3333, 4'd4);
    serve(1, 32'h0, 1'b0, 4'b1000, o);
    predict(3, 1, 32'h0, 1'b0, ecyc, eerr, edo, etmo);
    check_obs("wrap.req3", o, 3, ecyc, eerr, edo, etmo);
    raise(1, 1'b0, 32'h0000_D100, 32'h0, 4'd2);
    raise(2, 1'b0, 32'h0000_D200, 32'h0, 4'd1);
    serve(2, 32'h0101, 1'b0, 4'b0010, o);
    predict(1, 2, 32'h0101, 1'b0, ecyc, eerr, edo, etmo);
    check_obs("wrap.req1", o, 1, ecyc, eerr, edo, etmo);
    serve(1, 32'h0202, 1'b0, 4'b0100, o);
    predict(2, 1, 32'h0202, 1'b0, ecyc, eerr, edo, etmo);
    check_obs("wrap.req2", o, 2, ecyc, eerr, edo, etmo);

    // Randomized traffic against the round-robin model
    do_reset();
    last_m = N - 1;
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_strb[k] && $urandom_range(1, 0) == 1) begin
          case ($urandom_range(2, 0))
            0:       ws = 4'd1;
            1:       ws = 4'd2;
            default: ws = 4'd4;
          endcase
          raise(k, 1'($urandom_range(1, 0)), $urandom, $urandom, ws);
        end
      end
      if (req_strb == '0) begin
        raise(int'($urandom_range(N - 1, 0)), 1'b0, $urandom, $urandom, 4'd4);
      end
      w = -1;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && req_strb[(last_m + 1 + i) % N]) w = (last_m + 1 + i) % N;
      end
      d    = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(TMO, 1));
      bdo  = $urandom;
      berr = 1'($urandom_range(1, 0));
      serve(d, bdo, berr, 4'(1) << w, o);
      predict(w, d, bdo, berr, ecyc, eerr, edo, etmo);
      check_obs($sformatf("rnd%0d", t), o, w, ecyc, eerr, edo, etmo);
      last_m = w;
    end
    req_strb = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
